// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg: opcode classes and state codes
// shared by the sequencer, its timer and the bench.
package cpu_sequencer_pkg;

    localparam logic [3:0] OP_HLT = 4'h0;
    localparam logic [3:0] OP_LDW = 4'hA;
    localparam logic [3:0] OP_STW = 4'hB;
    localparam logic [3:0] OP_BRZ = 4'hC;
    localparam logic [3:0] OP_JAL = 4'hD;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } seq_state_e;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDW) || (op == OP_STW);
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: datapath-facing bundle of the sequencer;
// master is the sequencer, slave is the datapath side.
interface cpu_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       opcode;
    logic             zero_flag;
    logic             mem_ready;
    logic             run;
    logic             step;
    logic             ir_load;
    logic             alu_en;
    logic             mem_ren;
    logic             mem_wen;
    logic             reg_wen;
    logic             pc_inc;
    logic             pc_en;
    logic [2:0]       state;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, zero_flag, mem_ready, run, step,
        output ir_load, alu_en, mem_ren, mem_wen, reg_wen,
        output pc_inc, pc_en, state, halted, fault, retired
    );

    modport slave (
        output opcode, zero_flag, mem_ready, run, step,
        input  ir_load, alu_en, mem_ren, mem_wen, reg_wen,
        input  pc_inc, pc_en, state, halted, fault, retired
    );
endinterface

// File: rtl/cpu_sequencer_mem_wait_timer.sv
// cpu_sequencer_mem_wait_timer: counts MEM-state cycles and
// flags the last permitted cycle before a timeout fault.
module cpu_sequencer_mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    // expired is high during the TIMEOUT-th waiting cycle
    assign o_expired = i_en && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control
// with RAM wait timeout, HLT lock and run/single-step.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input logic            clk,
    input logic            rst,
    cpu_sequencer_if.master bus
);
    seq_state_e       r_state;
    seq_state_e       w_next;
    logic [3:0]       r_op;
    logic             r_stepping;
    logic             r_hlt_lock;
    logic             r_fault;
    logic [CNT_W-1:0] r_retired;

    logic w_go, w_cont, w_mem, w_expired;
    logic w_done, w_hlt, w_fault_set;
    logic w_ir_load, w_alu_en, w_mem_ren, w_mem_wen;
    logic w_reg_wen, w_pc_inc, w_pc_en;

    assign w_go   = !r_fault &&
                    (bus.step || (bus.run && !r_hlt_lock));
    assign w_cont = bus.run && !r_stepping;
    assign w_mem  = (r_state == S_MEM);

    cpu_sequencer_mem_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (!w_mem),
        .i_en      (w_mem),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next      = r_state;
        w_ir_load   = 1'b0;
        w_alu_en    = 1'b0;
        w_mem_ren   = 1'b0;
        w_mem_wen   = 1'b0;
        w_reg_wen   = 1'b0;
        w_pc_inc    = 1'b0;
        w_pc_en     = 1'b0;
        w_done      = 1'b0;
        w_hlt       = 1'b0;
        w_fault_set = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_go) w_next = S_FETCH;
            end
            S_FETCH: begin
                w_ir_load = 1'b1;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                if (bus.opcode == OP_HLT) begin
                    w_hlt  = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_alu_en = 1'b1;
                if (is_mem_op(r_op)) begin
                    w_next = S_MEM;
                end else if (r_op == OP_BRZ) begin
                    w_pc_en  = bus.zero_flag;
                    w_pc_inc = !bus.zero_flag;
                    w_done   = 1'b1;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                w_mem_ren = (r_op == OP_LDW);
                w_mem_wen = (r_op == OP_STW);
                if (bus.mem_ready) begin
                    if (r_op == OP_STW) begin
                        w_pc_inc = 1'b1;
                        w_done   = 1'b1;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_expired) begin
                    w_fault_set = 1'b1;
                    w_next      = S_IDLE;
                end
            end
            S_WB: begin
                w_reg_wen = 1'b1;
                w_pc_en   = (r_op == OP_JAL);
                w_pc_inc  = (r_op != OP_JAL);
                w_done    = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_done) w_next = w_cont ? S_FETCH : S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_stepping <= 1'b0;
            r_hlt_lock <= 1'b0;
            r_fault    <= 1'b0;
            r_retired  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_op <= bus.opcode;
            if (r_state == S_IDLE) begin
                r_stepping <= w_go && bus.step;
                if (!bus.run) r_hlt_lock <= 1'b0;
            end else if (w_done && !w_cont) begin
                r_stepping <= 1'b0;
            end
            if (w_hlt) r_hlt_lock <= 1'b1;
            if (w_fault_set) r_fault <= 1'b1;
            if (w_done) r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign bus.ir_load = w_ir_load;
    assign bus.alu_en  = w_alu_en;
    assign bus.mem_ren = w_mem_ren;
    assign bus.mem_wen = w_mem_wen;
    assign bus.reg_wen = w_reg_wen;
    assign bus.pc_inc  = w_pc_inc;
    assign bus.pc_en   = w_pc_en;
    assign bus.state   = r_state;
    assign bus.halted  = (r_state == S_IDLE);
    assign bus.fault   = r_fault;
    assign bus.retired = r_retired;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: table vectors, hand sequences and random
// instructions checked against an instruction-level model.
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    typedef struct {
        logic [3:0] op;
        logic       z;
        int         waits;
        int         lat;
        int         inc;
        int         en;
        int         ren;
        int         wen;
        int         regw;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_sequencer_if #(.CNT_W(16)) bus ();

    cpu_sequencer #(
        .MEM_TIMEOUT (15),
        .CNT_W       (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] exp_ret = '0;
    vec_t        tbl[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [6:0] strobes();
        return {bus.ir_load, bus.alu_en, bus.mem_ren, bus.mem_wen,
                bus.reg_wen, bus.pc_inc, bus.pc_en};
    endfunction

    // instruction-level view: phase count and which PC action occurs
    function automatic vec_t model(input logic [3:0] op, input logic z,
                                   input int waits);
        vec_t v;
        bit mem, wb, redirect;
        mem      = (op == OP_LDW) || (op == OP_STW);
        wb       = !((op == OP_STW) || (op == OP_BRZ));
        redirect = (op == OP_JAL) || ((op == OP_BRZ) && z);
        v.op    = op;
        v.z     = z;
        v.waits = waits;
        v.lat   = 3 + (mem ? waits + 1 : 0) + (wb ? 1 : 0);
        v.en    = redirect ? 1 : 0;
        v.inc   = redirect ? 0 : 1;
        v.ren   = (op == OP_LDW) ? waits + 1 : 0;
        v.wen   = (op == OP_STW) ? waits + 1 : 0;
        v.regw  = wb ? 1 : 0;
        return v;
    endfunction

    task automatic run_instr(input logic [3:0] op, input logic z,
                             input int waits, input bit do_step,
                             output int lat, output int inc,
                             output int en, output int ren,
                             output int wen, output int regw,
                             output bit done);
        int memc;
        bit started;
        memc = 0; started = 0; done = 0;
        lat = 0; inc = 0; en = 0; ren = 0; wen = 0; regw = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk);
            #1;
            bus.opcode    = op;
            bus.zero_flag = z;
            bus.step      = do_step && (c == 0);
            bus.mem_ready = (bus.state == S_MEM) && (memc == waits);
            #1;
            if (bus.ir_load && !started) begin
                started = 1;
                chk("retired_at_fetch", bus.retired, exp_ret);
            end
            if (started) begin
                lat++;
                inc  += bus.pc_inc;
                en   += bus.pc_en;
                ren  += bus.mem_ren;
                wen  += bus.mem_wen;
                regw += bus.reg_wen;
                if (bus.state == S_MEM) memc++;
                if (bus.pc_inc || bus.pc_en) done = 1;
            end
        end
    endtask

    task automatic apply(input string tag, input vec_t v,
                         input bit do_step);
        int lat, inc, en, ren, wen, regw;
        bit done;
        run_instr(v.op, v.z, v.waits, do_step,
                  lat, inc, en, ren, wen, regw, done);
        chk({tag, ".done"}, done, 1);
        chk({tag, ".lat"}, lat, v.lat);
        chk({tag, ".pc_inc"}, inc, v.inc);
        chk({tag, ".pc_en"}, en, v.en);
        chk({tag, ".mem_ren"}, ren, v.ren);
        chk({tag, ".mem_wen"}, wen, v.wen);
        chk({tag, ".reg_wen"}, regw, v.regw);
        exp_ret++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   nl, npc;
        logic [3:0] rop;
        vec_t v;
        bit   found;
        int   lat, inc, en, ren, wen, regw;
        bit   done;

        //                op     z     w   lat inc en ren wen reg
        tbl[0] = '{4'h1, 1'b0, 0,  4, 1, 0, 0,  0,  1};
        tbl[1] = '{4'hF, 1'b1, 0,  4, 1, 0, 0,  0,  1};
        tbl[2] = '{OP_BRZ, 1'b1, 0, 3, 0, 1, 0,  0,  0};
        tbl[3] = '{OP_BRZ, 1'b0, 0, 3, 1, 0, 0,  0,  0};
        tbl[4] = '{OP_JAL, 1'b0, 0, 4, 0, 1, 0,  0,  1};
        tbl[5] = '{OP_STW, 1'b0, 0, 4, 1, 0, 0,  1,  0};
        tbl[6] = '{OP_STW, 1'b1, 3, 7, 1, 0, 0,  4,  0};
        tbl[7] = '{OP_LDW, 1'b0, 2, 7, 1, 0, 3,  0,  1};
        tbl[8] = '{OP_LDW, 1'b0, 0, 5, 1, 0, 1,  0,  1};
        tbl[9] = '{OP_LDW, 1'b1, 14, 19, 1, 0, 15, 0, 1};

        rst = 1'b0;
        bus.opcode = '0;
        bus.zero_flag = 1'b0;
        bus.mem_ready = 1'b0;
        bus.run = 1'b0;
        bus.step = 1'b0;
        tick();
        tick();
        chk("rst.state", bus.state, 0);
        chk("rst.halted", bus.halted, 1);
        chk("rst.fault", bus.fault, 0);
        chk("rst.retired", bus.retired, 0);
        chk("rst.strobes", strobes(), 0);

        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.run = 1'b1;

        for (int i = 0; i < 10; i++)
            apply($sformatf("tbl%0d", i), tbl[i], 1'b0);

        // HLT parks in IDLE until run goes low and high again
        bus.opcode = OP_HLT;
        nl = 0;
        npc = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            nl  += bus.ir_load;
            npc += bus.pc_inc + bus.pc_en;
        end
        chk("hlt.fetches", nl, 1);
        chk("hlt.pc", npc, 0);
        chk("hlt.state", bus.state, 0);
        chk("hlt.retired", bus.retired, exp_ret);
        bus.run = 1'b0;
        tick();
        tick();
        bus.run = 1'b1;
        apply("hlt_rerun", tbl[0], 1'b0);

        bus.run = 1'b0;
        tick();
        tick();
        tick();
        chk("stop.state", bus.state, 0);
        chk("stop.halted", bus.halted, 1);
        apply("step", tbl[0], 1'b1);
        tick();
        tick();
        tick();
        chk("step.state", bus.state, 0);
        chk("step.halted", bus.halted, 1);
        chk("step.retired", bus.retired, exp_ret);

        bus.run = 1'b1;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 5))
                0: rop = 4'($urandom_range(1, 9));
                1: rop = ($urandom_range(0, 1) == 1) ? 4'hE : 4'hF;
                2: rop = OP_LDW;
                3: rop = OP_STW;
                4: rop = OP_BRZ;
                default: rop = OP_JAL;
            endcase
            v = model(rop, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 6));
            apply($sformatf("rnd%0d", i), v, 1'b0);
        end

        // reset in the middle of a RAM write
        bus.opcode = OP_STW;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk);
            #1;
            bus.mem_ready = 1'b0;
            #1;
            if (bus.state == S_MEM) found = 1;
        end
        chk("mrst.in_mem", found, 1);
        chk("mrst.wen_before", bus.mem_wen, 1);
        #1;
        rst = 1'b0;
        #1;
        chk("mrst.wen", bus.mem_wen, 0);
        chk("mrst.state", bus.state, 0);
        chk("mrst.retired", bus.retired, 0);
        exp_ret = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // RAM never answers: fault after 15 MEM cycles
        run_instr(OP_STW, 1'b0, 99, 1'b0,
                  lat, inc, en, ren, wen, regw, done);
        chk("tmo.done", done, 0);
        chk("tmo.wen_cycles", wen, 15);
        chk("tmo.pc", inc + en, 0);
        chk("tmo.fault", bus.fault, 1);
        chk("tmo.state", bus.state, 0);
        bus.step = 1'b1;
        tick();
        tick();
        tick();
        chk("tmo.step_ign", bus.state, 0);
        chk("tmo.retired", bus.retired, 0);
        bus.step = 1'b0;
        rst = 1'b0;
        #1;
        chk("tmo.fault_clr", bus.fault, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule
